vram_circle_renderer: RTL

- Runtime successor to the power-up circle fill of the VRAM image.
- Scans the full frame once per command and writes every pixel of the VRAM through a valid/ready write port.
- Colours each pixel by a geometric test against a programmable circle: filled disk, ring of programmable thickness, or full clear.
- Sits between the system command logic and the VRAM write side. The VGAC read path is untouched.

---
 rtl/vram_circle_renderer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/vram_circle_renderer.sv
// Frame-scanning circle renderer: walks every VRAM pixel in raster order and
// writes a disk, ring or clear colour through a valid/ready write port.
module vram_circle_renderer #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9,
    parameter int PIX_W = 12
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [COL_W-1:0] cx,
    input  logic [ROW_W-1:0] cy,
    input  logic [COL_W-1:0] radius,
    input  logic [COL_W-1:0] thick,
    input  logic [PIX_W-1:0] fg_color,
    input  logic [PIX_W-1:0] bg_color,
    output logic             wr_valid,
    input  logic             wr_ready,
    output logic [ROW_W-1:0] wr_row,
    output logic [COL_W-1:0] wr_col,
    output logic [PIX_W-1:0] wr_data,
    output logic             busy,
    output logic             done
);

    localparam int MAX_W = (COL_W > ROW_W) ? COL_W : ROW_W;
    localparam int D_W   = 2 * MAX_W + 2;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_RES - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_RES - 1);

    typedef enum logic [1:0] {IDLE, SCAN, FINISH} state_t;

    state_t state, state_next;

    logic [ROW_W-1:0] row_cnt;
    logic [COL_W-1:0] col_cnt;
    logic [1:0]       mode_q;
    logic [COL_W-1:0] cx_q;
    logic [ROW_W-1:0] cy_q;
    logic [COL_W-1:0] radius_q;
    logic [COL_W-1:0] thick_q;
    logic [PIX_W-1:0] fg_q;
    logic [PIX_W-1:0] bg_q;

    logic signed [COL_W:0] dx;
    logic signed [ROW_W:0] dy;
    logic signed [D_W-1:0] dx_w, dy_w;
    logic [D_W-1:0]        d2, ro2, ri2, rad_w, ri_w;
    logic [COL_W-1:0]      ri;
    logic                  in_outer, in_inner, last_pix;
    logic [PIX_W-1:0]      pix;

    assign last_pix = (row_cnt == ROW_LAST) && (col_cnt == COL_LAST);
    assign wr_row   = row_cnt;
    assign wr_col   = col_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        wr_valid   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SCAN;
            end
            SCAN: begin
                wr_valid = 1'b1;
                busy     = 1'b1;
                if (wr_ready && last_pix) state_next = FINISH;
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Command parameters are captured only in IDLE, so start or input changes
    // during a scan cannot disturb the image being written.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            row_cnt  <= '0;
            col_cnt  <= '0;
            mode_q   <= '0;
            cx_q     <= '0;
            cy_q     <= '0;
            radius_q <= '0;
            thick_q  <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        row_cnt  <= '0;
                        col_cnt  <= '0;
                        mode_q   <= mode;
                        cx_q     <= cx;
                        cy_q     <= cy;
                        radius_q <= radius;
                        thick_q  <= thick;
                        fg_q     <= fg_color;
                        bg_q     <= bg_color;
                    end
                end
                SCAN: begin
                    if (wr_ready) begin
                        if (col_cnt == COL_LAST) begin
                            col_cnt <= '0;
                            row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                        end else begin
                            col_cnt <= col_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Squared distances are widened to D_W so the sums can never overflow,
    // even with the centre in a far corner of the counter range.
    always_comb begin
        dx    = signed'({1'b0, col_cnt}) - signed'({1'b0, cx_q});
        dy    = signed'({1'b0, row_cnt}) - signed'({1'b0, cy_q});
        dx_w  = D_W'(dx);
        dy_w  = D_W'(dy);
        d2    = unsigned'(dx_w * dx_w) + unsigned'(dy_w * dy_w);
        ri    = (thick_q >= radius_q) ? '0 : radius_q - thick_q;
        rad_w = D_W'(radius_q);
        ri_w  = D_W'(ri);
        ro2   = rad_w * rad_w;
        ri2   = ri_w * ri_w;
        in_outer = (d2 < ro2);
        in_inner = (d2 < ri2);
    end

    always_comb begin
        pix = bg_q;
        case (mode_q)
            2'b00: if (in_outer) pix = fg_q;
            2'b01: if (in_outer && !in_inner) pix = fg_q;
            default: pix = bg_q;
        endcase
        wr_data = (state == SCAN) ? pix : '0;
    end

endmodule
